// File: rtl/snoop_bus_controller.sv
// Shared MSI snooping-bus sequencer: round-robin grant, one-cycle broadcast,
// snoop write-back collection, then memory write-back/fetch and a done pulse.
module snoop_bus_controller #(
   parameter int N_CPU  = 4,
   parameter int ADDR_W = 8,
   localparam int SRC_W = (N_CPU > 1) ? $clog2(N_CPU) : 1
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic [N_CPU-1:0]          req,
   input  logic [2*N_CPU-1:0]        req_op,
   input  logic [ADDR_W*N_CPU-1:0]   req_addr,
   input  logic [N_CPU-1:0]          snoop_wb,
   input  logic                      mem_ack,
   output logic [N_CPU-1:0]          grant,
   output logic                      bus_valid,
   output logic [1:0]                bus_op,
   output logic [ADDR_W-1:0]         bus_addr,
   output logic [SRC_W-1:0]          bus_src,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [N_CPU-1:0]          done,
   output logic                      busy
);

   localparam logic [1:0] OP_RM  = 2'b00;
   localparam logic [1:0] OP_WM  = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BCAST,
      S_SNOOP,
      S_WRITEBACK,
      S_FETCH,
      S_DONE
   } state_t;

   state_t            state;
   logic [SRC_W-1:0]  last;

   logic              sel_found;
   logic [SRC_W-1:0]  sel_idx;
   logic [SRC_W-1:0]  cand;
   logic [N_CPU-1:0]  sel_onehot;
   logic [1:0]        sel_op;
   logic [ADDR_W-1:0] sel_addr;
   logic              wb_pending;
   logic              op_is_rw;

   // Scan downwards so the closest requester after 'last' is the final winner.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      cand       = '0;
      sel_onehot = '0;
      sel_op     = '0;
      sel_addr   = '0;
      for (int k = N_CPU; k >= 1; k--) begin
         cand = SRC_W'((int'(last) + k) % N_CPU);
         if (req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
      for (int i = 0; i < N_CPU; i++) begin
         if (sel_idx == SRC_W'(i)) begin
            sel_onehot[i] = 1'b1;
            sel_op        = req_op[2*i +: 2];
            sel_addr      = req_addr[ADDR_W*i +: ADDR_W];
         end
      end
   end

   // The requester's own snoop response never forces a write-back.
   assign wb_pending = |(snoop_wb & ~grant);
   assign op_is_rw   = (bus_op == OP_RM) || (bus_op == OP_WM);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         last      <= SRC_W'(N_CPU - 1);
         grant     <= '0;
         bus_valid <= 1'b0;
         bus_op    <= '0;
         bus_addr  <= '0;
         bus_src   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         done      <= '0;
         busy      <= 1'b0;
      end else begin
         bus_valid <= 1'b0;
         done      <= '0;
         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  grant     <= sel_onehot;
                  bus_src   <= sel_idx;
                  bus_op    <= sel_op;
                  bus_addr  <= sel_addr;
                  last      <= sel_idx;
                  busy      <= 1'b1;
                  bus_valid <= (sel_op != OP_RSV);
                  state     <= S_BCAST;
               end
            end
            // A reserved op spends this cycle silently so its done lands in cycle 2.
            S_BCAST: begin
               if (bus_op == OP_RSV) begin
                  done  <= grant;
                  state <= S_DONE;
               end else begin
                  state <= S_SNOOP;
               end
            end
            S_SNOOP: begin
               if (wb_pending) begin
                  mem_req <= 1'b1;
                  mem_we  <= 1'b1;
                  state   <= S_WRITEBACK;
               end else if (op_is_rw) begin
                  mem_req <= 1'b1;
                  mem_we  <= 1'b0;
                  state   <= S_FETCH;
               end else begin
                  done  <= grant;
                  state <= S_DONE;
               end
            end
            S_WRITEBACK: begin
               if (mem_ack) begin
                  mem_we <= 1'b0;
                  if (op_is_rw) begin
                     state <= S_FETCH;
                  end else begin
                     mem_req <= 1'b0;
                     done    <= grant;
                     state   <= S_DONE;
                  end
               end
            end
            S_FETCH: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  done    <= grant;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               grant    <= '0;
               bus_op   <= '0;
               bus_addr <= '0;
               bus_src  <= '0;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
